frame_ddc_data_rx: RTL
======================

// Module: frame_ddc_data_rx
// PURPOSE
//  Receive end of the DDC frame link. Parses the 64-bit beat stream: sync word, header, then I/Q payload.
//  Beats are packed in pairs into 128-bit words and written to a DDC data RAM.
//  Reports header fields, frame completion and framing errors.
//  Sits between the link deframer/FIFO output and the downstream DDC sample RAM.
// PARAMETERS
//  ADDR_W     14                     RAM word address width
//  MAX_WORDS  11100                  largest legal length field in 128-bit words (370*30)
//  SYNC_WORD  64'hA5A5123401020304   frame start marker
//  EXP_TYPE   16'h0001               only accepted frame_type
// PORTS
//  clk              in   1       user clock; all logic on rising edge
//  rst_n            in   1       asynchronous active-low reset
//  enable           in   1       receive enable; low = synchronous abort to IDLE
//  data_frame       in   64      beat data; bit 63 = first transmitted bit
//  data_frame_valid in   1       beat qualifier; gaps of any length allowed
//  data_frame_last  in   1       final beat of frame; meaningful only with valid
//  ram_wr           out  1       RAM write strobe, one cycle per 128-bit word
//  ram_addr         out  ADDR_W  RAM word address, 0 for first payload word
//  ram_din          out  128     {even beat, odd beat} = {I1,Q1,I2,Q2,I3,Q3,I4,Q4}
//  frame_type       out  16      header field 63:48, held until next header
//  frame_length     out  16      header field 47:32 (payload words), held
//  frame_dst_addr   out  16      header field 31:16, held
//  frame_src_addr   out  16      header field 15:0, held
//  frame_done       out  1       1-cycle pulse: frame received without error
//  frame_err        out  1       1-cycle pulse: frame aborted on error
//  err_code         out  3       cause of last error; held until next SYNC accept
//  frame_count      out  16      count of good frames; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE.
//  enable=0 (synchronous): same values as reset, except frame_count and the header fields hold.
//  Only beats with valid=1 are consumed. Beats arriving with valid=0 are ignored in every state.
//  States:
//   IDLE: beat==SYNC_WORD -> HDR and err_code<=0. Any other beat is discarded and state stays IDLE.
//    last in IDLE is ignored.
//   HDR: latch the 4 header fields, clear beat/word counters. Then go:
//    last=1 -> DROP-free error SHORT(1), back to IDLE;
//    length==0 or >MAX_WORDS -> LEN(3);
//    type!=EXP_TYPE -> TYPE(4);
//    otherwise -> DATA_HI.
//    LEN and TYPE errors go to DROP.
//   DATA_HI: beat -> ram_din[127:64] holding reg.
//    last=1 here -> SHORT(1), IDLE.
//    Otherwise -> DATA_LO.
//   DATA_LO: on the next cycle, ram_wr=1 with ram_din={hi,beat} and ram_addr=word_cnt; then word_cnt++.
//    Final word (word_cnt==length-1) with last=1 -> frame_done pulse, frame_count++, IDLE.
//    Final word with last=0 -> NO_LAST(2), DROP.
//    Non-final word with last=1 -> SHORT(1), IDLE; the already-written words stay in RAM.
//    Otherwise -> DATA_HI.
//   DROP: discard beats until a beat with last=1, then IDLE.
//  Every error: frame_err pulses in the cycle after the offending beat, together with the err_code update.
//  Latency: ram_wr and frame_done are registered 1 cycle after the completing beat.
//   frame_done coincides with the final ram_wr.
//  SYNC_WORD seen mid-payload is treated as data. No resync.
//  word_cnt is ADDR_W bits and cannot wrap, because MAX_WORDS <= 2^ADDR_W - 1.
//  Back-to-back frames: a SYNC beat arriving on the cycle after last is accepted.
// STRUCTURE
//  Package frame_ddc_pkg holds:
//   SYNC_WORD, EXP_TYPE;
//   ERR_NONE/SHORT/NO_LAST/LEN/TYPE = 0..4;
//   state encoding IDLE/HDR/DATA_HI/DATA_LO/DROP.
//  Shared with the frame transmitter.
//  One sub-module, frame_ddc_hdr_check: combinational header decode and legality check.
//   Returns an err code, so that the transmitter test model can reuse it.
// TESTING
//  - Good frame, length=2, continuous valid: SYNC, {0001,0002,0000,0000}, 4 beats, last on beat 4.
//    Expect ram_wr at addr 0,1 with 128-bit concatenations.
//    Expect frame_done=1 once, frame_count=1.
//  - Same frame with valid toggled 1/0 every cycle: identical RAM writes and a single frame_done.
//  - Length=3 with last on payload beat 4: expect frame_err, err_code=1, 2 writes only, IDLE.
//    Next good frame is accepted.
//  - Length=2 with no last on beat 4, last on beat 6: expect err_code=2 and beats 5-6 dropped.
//  - Header length=0, then length=11101, then type=16'h0002: expect err_code 3, 3, 4.
//    Expect no ram_wr; each frame_err is followed by DROP until last.
//  - Garbage beats before SYNC, enable deasserted mid-payload, rst_n pulsed mid-frame:
//    IDLE reached each time and outputs return to their reset values.
//    The following good frame writes from addr 0.

Source files
------------

// File: rtl/frame_ddc_pkg.sv
// Shared DDC frame link definitions: sync marker, accepted frame type, error codes, parser states.
// Used by both the receive parser and the frame transmitter model.
// No logic; constants and types only.
package frame_ddc_pkg;

    localparam logic [63:0] SYNC_WORD = 64'hA5A5_1234_0102_0304;
    localparam logic [15:0] EXP_TYPE  = 16'h0001;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SHORT   = 3'd1;
    localparam logic [2:0] ERR_NO_LAST = 3'd2;
    localparam logic [2:0] ERR_LEN     = 3'd3;
    localparam logic [2:0] ERR_TYPE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        DROP    = 3'd4
    } state_t;

    typedef struct packed {
        logic [15:0] ftype;
        logic [15:0] length;
        logic [15:0] dst_addr;
        logic [15:0] src_addr;
    } hdr_t;

endpackage

// File: rtl/frame_ddc_hdr_check.sv
// Header beat decode and legality check; a premature last outranks field errors.
// Latency: combinational.
// Backpressure: none, pure function of the presented beat.
module frame_ddc_hdr_check
    import frame_ddc_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 11100
) (
    input  logic [63:0] beat,
    input  logic        last,
    output hdr_t        hdr,
    output logic [2:0]  err
);

    assign hdr = hdr_t'(beat);

    always_comb begin
        err = ERR_NONE;
        if (last)
            err = ERR_SHORT;
        else if (hdr.length == 16'd0 || hdr.length > 16'(MAX_WORDS))
            err = ERR_LEN;
        else if (hdr.ftype != EXP_TYPE)
            err = ERR_TYPE;
    end

endmodule

// File: rtl/frame_ddc_data_rx.sv
// DDC frame receiver: SYNC/header/payload parser packing beat pairs into 128-bit RAM words.
// Latency: ram_wr, frame_done and frame_err are registered one cycle after the deciding beat.
// Backpressure: none; beats are consumed whenever valid, idle gaps of any length are tolerated.
module frame_ddc_data_rx
    import frame_ddc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MAX_WORDS = 11100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [63:0]       data_frame,
    input  logic              data_frame_valid,
    input  logic              data_frame_last,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [127:0]      ram_din,
    output logic [15:0]       frame_type,
    output logic [15:0]       frame_length,
    output logic [15:0]       frame_dst_addr,
    output logic [15:0]       frame_src_addr,
    output logic              frame_done,
    output logic              frame_err,
    output logic [2:0]        err_code,
    output logic [15:0]       frame_count
);

    state_t            state;
    logic [63:0]       hi_dat;
    logic [ADDR_W-1:0] word_cnt;
    hdr_t              hdr_dec;
    logic [2:0]        hdr_err;
    logic              last_word;

    frame_ddc_hdr_check #(.MAX_WORDS(MAX_WORDS)) u_hdr_check (
        .beat (data_frame),
        .last (data_frame_last),
        .hdr  (hdr_dec),
        .err  (hdr_err)
    );

    assign last_word = (16'(word_cnt) == frame_length - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            hi_dat         <= '0;
            word_cnt       <= '0;
            ram_wr         <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            frame_type     <= '0;
            frame_length   <= '0;
            frame_dst_addr <= '0;
            frame_src_addr <= '0;
            frame_done     <= 1'b0;
            frame_err      <= 1'b0;
            err_code       <= ERR_NONE;
            frame_count    <= '0;
        end else if (!enable) begin
            // Abort: header fields and good-frame count survive, everything else clears.
            state      <= IDLE;
            hi_dat     <= '0;
            word_cnt   <= '0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            ram_wr     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (data_frame_valid) begin
                case (state)
                    IDLE: begin
                        if (data_frame == SYNC_WORD) begin
                            state    <= HDR;
                            err_code <= ERR_NONE;
                        end
                    end
                    HDR: begin
                        frame_type     <= hdr_dec.ftype;
                        frame_length   <= hdr_dec.length;
                        frame_dst_addr <= hdr_dec.dst_addr;
                        frame_src_addr <= hdr_dec.src_addr;
                        word_cnt       <= '0;
                        if (hdr_err == ERR_NONE) begin
                            state <= DATA_HI;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= hdr_err;
                            // A header already carrying last has nothing left to drop.
                            state     <= (hdr_err == ERR_SHORT) ? IDLE : DROP;
                        end
                    end
                    DATA_HI: begin
                        hi_dat <= data_frame;
                        if (data_frame_last) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_SHORT;
                            state     <= IDLE;
                        end else begin
                            state <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        ram_wr   <= 1'b1;
                        ram_addr <= word_cnt;
                        ram_din  <= {hi_dat, data_frame};
                        word_cnt <= word_cnt + ADDR_W'(1);
                        if (last_word) begin
                            if (data_frame_last) begin
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                state       <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_NO_LAST;
                                state     <= DROP;
                            end
                        end else if (data_frame_last) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_SHORT;
                            state     <= IDLE;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                    DROP: begin
                        if (data_frame_last)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
